// File: rtl/rip_fifo_pkg.sv
// Shared types and helpers for the rip_fifo write-side arbitration logic.
package rip_fifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rip_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rip_rr_arbiter
  import rip_fifo_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int unsigned idx;
  int unsigned pick;
  logic        found;

  // Walk the requests in rotated order starting at ptr; the first hit wins.
  always_comb begin
    any     = |req;
    found   = 1'b0;
    pick    = 0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    gnt_idx = IW'(pick);
    gnt     = found ? (N'(1) << pick) : '0;
  end

endmodule

// File: rtl/rip_fifo_wr_arbiter.sv
// Packet-granular round-robin sharing of one rip_fifo_async write port among N_REQ requesters.
module rip_fifo_wr_arbiter
  import rip_fifo_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned DATA_WIDTH = 128,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned ID_W       = clog2_min1(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_w_data,
  input  logic                        fifo_w_full,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic                        err_burst
);

  localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BURST + 1);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [N_REQ-1:0] grant_oh;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;
  logic [ID_W-1:0]  ptr_next;

  logic             burst;
  logic             sel_valid;
  logic             sel_last;
  logic             accept;
  logic [DATA_WIDTH-1:0] mux_data;

  rip_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign ptr_next = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // Owner's beat passes straight through; full stalls without any state change.
  always_comb begin
    burst     = (state == ARB_BURST);
    sel_valid = |(req_valid & grant_oh);
    sel_last  = |(req_last & grant_oh);
    accept    = burst && sel_valid && !fifo_w_full;
    req_ready = (burst && !fifo_w_full) ? grant_oh : '0;
    fifo_w_en = accept;
    mux_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) mux_data = mux_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    fifo_w_data = mux_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      grant_oh    <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_burst   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (arb_any) begin
            grant_id    <= arb_idx;
            grant_oh    <= arb_gnt;
            grant_valid <= 1'b1;
            rr_ptr      <= ptr_next;
            beat_cnt    <= '0;
            state       <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (accept) begin
            // Beat MAX_BURST+1 of a packet marks it over-length, last or not.
            if (beat_cnt == CNT_MAX) err_burst <= 1'b1;
            if (sel_last) begin
              state       <= ARB_IDLE;
              grant_valid <= 1'b0;
              grant_oh    <= '0;
              beat_cnt    <= '0;
            end else if (beat_cnt != CNT_SAT) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
